// File: rtl/soqpsk_pkg.sv
// Shared types and constants for the SOQPSK lookup-ROM address generator.
package soqpsk_pkg;

    localparam logic [1:0] ALPHA_ZERO = 2'b00;
    localparam logic [1:0] ALPHA_POS  = 2'b01;
    localparam logic [1:0] ALPHA_NEG  = 2'b11;

    localparam int DEF_SPS      = 32;
    localparam int DEF_SAMPLE_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        RUN   = 2'b10
    } state_t;

    // Alpha codes are two's-complement, so a plain 2-bit add is quadrant + alpha mod 4.
    function automatic logic [1:0] quad_add(input logic [1:0] quad, input logic [1:0] alpha_code);
        return quad + alpha_code;
    endfunction

endpackage

// File: rtl/soqpsk_precoder.sv
// IRIG-106 SOQPSK ternary precoder: maps the last three payload bits and
// the bit-index parity to the alpha code for the bit currently being shaped.
module soqpsk_precoder
    import soqpsk_pkg::*;
(
    input  logic       i_a_k,
    input  logic       i_a_km1,
    input  logic       i_a_km2,
    input  logic       i_k_odd,
    output logic [1:0] o_alpha_code
);

    logic w_neg;

    // Sign is the product of three +/-1 factors; it is negative when an odd number of them is -1.
    assign w_neg = (~i_k_odd) ^ (~i_a_km1) ^ (~i_a_k);

    // Alpha selection
    always_comb begin
        o_alpha_code = ALPHA_ZERO;
        if (i_a_k == i_a_km2) begin
            o_alpha_code = ALPHA_ZERO;
        end else if (w_neg) begin
            o_alpha_code = ALPHA_NEG;
        end else begin
            o_alpha_code = ALPHA_POS;
        end
    end

endmodule

// File: rtl/soqpsk_lut_addr_gen.sv
// SOQPSK waveform-ROM address generator: primes the bit history, then emits
// {quadrant, alpha, sample index} per sample strobe with a ROM-aligned valid.
module soqpsk_lut_addr_gen
    import soqpsk_pkg::*;
#(
    parameter int   SPS      = DEF_SPS,
    parameter int   SAMPLE_W = DEF_SAMPLE_W,
    parameter int   ROM_LAT  = 2,
    parameter logic FILL_BIT = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sample_en,
    input  logic                  bit_data,
    input  logic                  bit_valid,
    output logic                  bit_ready,
    output logic [SAMPLE_W+3:0]   address,
    output logic                  addr_valid,
    output logic                  q_valid,
    output logic                  underrun
);

    state_t                r_state;
    logic [1:0]            r_prime_cnt;
    logic                  r_a_k;
    logic                  r_a_km1;
    logic                  r_a_km2;
    logic                  r_k_odd;
    logic [1:0]            r_quad;
    logic [SAMPLE_W-1:0]   r_idx;
    logic [SAMPLE_W+3:0]   r_addr;
    logic                  r_addr_valid;
    logic [ROM_LAT-1:0]    r_qv_dly;
    logic                  r_underrun;

    logic                  w_last_sample;
    logic                  w_next_bit;
    logic [1:0]            w_alpha_code;

    soqpsk_precoder u_precoder (
        .i_a_k        (r_a_k),
        .i_a_km1      (r_a_km1),
        .i_a_km2      (r_a_km2),
        .i_k_odd      (r_k_odd),
        .o_alpha_code (w_alpha_code)
    );

    assign w_last_sample = (r_idx == SAMPLE_W'(SPS - 1));
    assign w_next_bit    = bit_valid ? bit_data : FILL_BIT;
    // Gated by enable so a bit is never taken on the clock that aborts to IDLE.
    assign bit_ready     = enable && ((r_state == PRIME) ||
                                      ((r_state == RUN) && sample_en && w_last_sample));

    assign address    = r_addr;
    assign addr_valid = r_addr_valid;
    assign q_valid    = r_qv_dly[ROM_LAT-1];
    assign underrun   = r_underrun;

    // Sequencer, history, quadrant accumulator, sample counter and valid delay line
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_state      <= IDLE;
            r_prime_cnt  <= 2'd0;
            r_a_k        <= 1'b0;
            r_a_km1      <= 1'b0;
            r_a_km2      <= 1'b0;
            r_k_odd      <= 1'b0;
            r_quad       <= 2'd0;
            r_idx        <= '0;
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_qv_dly     <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_addr_valid <= 1'b0;
            r_underrun   <= 1'b0;
            r_qv_dly[0]  <= r_addr_valid;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_qv_dly[i] <= r_qv_dly[i-1];
            end
            case (r_state)
                IDLE: begin
                    r_state     <= PRIME;
                    r_prime_cnt <= 2'd0;
                end
                PRIME: begin
                    if (bit_valid) begin
                        r_a_km2 <= r_a_km1;
                        r_a_km1 <= r_a_k;
                        r_a_k   <= bit_data;
                        if (r_prime_cnt == 2'd2) begin
                            r_state     <= RUN;
                            r_prime_cnt <= 2'd0;
                        end else begin
                            r_prime_cnt <= r_prime_cnt + 2'd1;
                        end
                    end
                end
                RUN: begin
                    if (sample_en) begin
                        r_addr       <= {r_quad, w_alpha_code, r_idx};
                        r_addr_valid <= 1'b1;
                        if (w_last_sample) begin
                            r_idx      <= '0;
                            r_quad     <= quad_add(r_quad, w_alpha_code);
                            r_a_km2    <= r_a_km1;
                            r_a_km1    <= r_a_k;
                            r_a_k      <= w_next_bit;
                            r_k_odd    <= ~r_k_odd;
                            r_underrun <= ~bit_valid;
                        end else begin
                            r_idx <= r_idx + SAMPLE_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soqpsk_lut_addr_gen.sv
// Scoreboard bench for soqpsk_lut_addr_gen: the driver predicts each response into
// queues, and a negedge monitor retires them as the DUT presents outputs.
module tb_soqpsk_lut_addr_gen;
    import soqpsk_pkg::*;

    localparam int SPS     = 32;
    localparam int ROM_LAT = 2;
    localparam logic [1:0] GOLD [16] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11,
                                         2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};

    typedef struct {
        logic [8:0] addr;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset, enable, sample_en, bit_data, bit_valid;
    logic       bit_ready, addr_valid, q_valid, underrun;
    logic [8:0] address;
    logic       p_ak, p_a1, p_a2, p_k;
    logic [1:0] p_code;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   und_q[$];
    int   qv_q[$];
    int   quad_q[$];
    bit   bits_q[$];
    bit   quad_chk = 1'b0;

    int         m_state, m_pcnt, m_idx;
    bit         m_ak, m_a1, m_a2, m_kodd;
    logic [1:0] m_quad;

    soqpsk_lut_addr_gen dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .sample_en  (sample_en),
        .bit_data   (bit_data),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .address    (address),
        .addr_valid (addr_valid),
        .q_valid    (q_valid),
        .underrun   (underrun)
    );

    soqpsk_precoder u_pre (
        .i_a_k        (p_ak),
        .i_a_km1      (p_a1),
        .i_a_km2      (p_a2),
        .i_k_odd      (p_k),
        .o_alpha_code (p_code)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string name, int info);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got none/extra, reference value %0d (cycle %0d)", name, info, cyc);
    endfunction

    // Golden precoder written straight from the +/-1 formula.
    function automatic int alpha_m(bit ak, bit a1, bit a2, bit kodd);
        int d;
        d = (ak ? 1 : -1) - (a2 ? 1 : -1);
        if (d == 0) return 0;
        return (kodd ? 1 : -1) * (a1 ? 1 : -1) * ((d > 0) ? 1 : -1);
    endfunction

    function automatic void model_reset();
        m_state = 0; m_pcnt = 0; m_idx = 0;
        m_ak = 1'b0; m_a1 = 1'b0; m_a2 = 1'b0; m_kodd = 1'b0;
        m_quad = 2'd0;
    endfunction

    function automatic void shift_in(bit b);
        m_a2 = m_a1;
        m_a1 = m_ak;
        m_ak = b;
    endfunction

    // Monitor: retires expectations whenever the DUT presents an output
    always @(negedge clock) begin
        exp_t e;
        int   qc;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            fail_now("addr_missing", int'(exp_q[0].addr));
            void'(exp_q.pop_front());
        end
        while (qv_q.size() > 0 && qv_q[0] + ROM_LAT < cyc) begin
            fail_now("q_valid_missing", qv_q[0]);
            void'(qv_q.pop_front());
        end
        while (und_q.size() > 0 && und_q[0] < cyc) begin
            fail_now("underrun_missing", und_q[0]);
            void'(und_q.pop_front());
        end
        if (addr_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("addr_unexpected", int'(address));
            end else begin
                e = exp_q.pop_front();
                check("address", int'(address), int'(e.addr));
                check("addr_cycle", cyc, e.cyc);
            end
            qv_q.push_back(cyc);
            if (quad_chk && address[4:0] == 5'd0 && quad_q.size() > 0) begin
                qc = quad_q.pop_front();
                check("quadrant_hand", int'(address[8:7]), qc);
                check("alpha_hand", int'(address[6:5]), 1);
            end
        end
        if (q_valid) begin
            if (qv_q.size() == 0) fail_now("q_valid_unexpected", cyc);
            else check("q_valid_latency", cyc - qv_q.pop_front(), ROM_LAT);
        end
        if (underrun) begin
            if (und_q.size() == 0) fail_now("underrun_unexpected", cyc);
            else check("underrun_cycle", cyc, und_q.pop_front());
        end
    end

    // One clock of stimulus: drive, predict, check bit_ready, advance.
    task automatic step(input bit en, input bit se);
        bit         rdy;
        bit         bv;
        bit         bd;
        int         a;
        logic [1:0] code;
        enable    = en;
        sample_en = se;
        bv        = (bits_q.size() > 0);
        bd        = bv ? bits_q[0] : 1'b0;
        bit_valid = bv;
        bit_data  = bd;
        rdy = en && ((m_state == 1) || (m_state == 2 && se && m_idx == SPS - 1));
        #1;
        check("bit_ready", int'(bit_ready), int'(rdy));
        if (rdy && bv) void'(bits_q.pop_front());
        if (!en) begin
            model_reset();
        end else if (m_state == 0) begin
            m_state = 1;
            m_pcnt  = 0;
        end else if (m_state == 1) begin
            if (bv) begin
                shift_in(bd);
                if (m_pcnt == 2) begin
                    m_state = 2;
                    m_pcnt  = 0;
                end else begin
                    m_pcnt++;
                end
            end
        end else if (se) begin
            a    = alpha_m(m_ak, m_a1, m_a2, m_kodd);
            code = (a == 0) ? 2'b00 : ((a > 0) ? 2'b01 : 2'b11);
            exp_q.push_back('{addr: {m_quad, code, 5'(m_idx)}, cyc: cyc + 1});
            if (m_idx == SPS - 1) begin
                m_quad = m_quad + 2'(a);
                shift_in(bv ? bd : 1'b0);
                if (!bv) und_q.push_back(cyc + 1);
                m_kodd = ~m_kodd;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end
        @(posedge clock);
        #1;
        if (!en) qv_q.delete();
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_address"}, int'(address), 0);
        check({tag, "_addr_valid"}, int'(addr_valid), 0);
        check({tag, "_q_valid"}, int'(q_valid), 0);
        check({tag, "_bit_ready"}, int'(bit_ready), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample_en = 1'b0; bit_data = 1'b0; bit_valid = 1'b0;
        {p_ak, p_a1, p_a2, p_k} = 4'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset");

        for (int i = 0; i < 16; i++) begin
            {p_ak, p_a1, p_a2, p_k} = 4'(i);
            #1;
            check("precoder", int'(p_code), int'(GOLD[i]));
        end

        // All-ones payload: alpha stays zero, addresses count 0..31 repeatedly.
        repeat (6) bits_q.push_back(1'b1);
        repeat (104) step(1'b1, 1'b1);

        // Reset pulse in the middle of RUN.
        reset = 1'b1; enable = 1'b1; sample_en = 1'b1; bit_valid = 1'b0;
        model_reset();
        bits_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete(); qv_q.delete(); und_q.delete();
        check_idle_outputs("midrun_reset");

        // 0,0,1,1 repeating gives alpha=+1 every bit; the final boundary underruns.
        bits_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        quad_q = '{0, 1, 2, 3, 0, 1};
        quad_chk = 1'b1;
        repeat (4 + 6 * SPS + 8) step(1'b1, 1'b1);
        quad_chk = 1'b0;
        check("quadrant_list_used", quad_q.size(), 0);

        // Sparse strobes, then an abort mid-bit, then a fresh prime.
        for (int i = 0; i < 60; i++) step(1'b1, (i % 3) == 0);
        for (int i = 0; i < 8; i++) step(1'b0, i[0]);
        bits_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        repeat (60) step(1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0);

        check("addr_queue_drained", exp_q.size(), 0);
        check("qv_queue_drained", qv_q.size(), 0);
        check("underrun_queue_drained", und_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
